// File: rtl/ntt_bfly_cfg_pipe_if.sv
// Beat-level bus of the configurable NTT butterfly: input beat, output beat and status.
interface ntt_bfly_cfg_pipe_if #(
    parameter int unsigned W = 33
) ();
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic         half;
    logic [W-1:0] xin;
    logic [W-1:0] yin;
    logic [W-1:0] wr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] xout;
    logic [W-1:0] yout;
    logic         busy;
    logic         err_range;

    // Producer/consumer side (memory read port and write-back port)
    modport master (
        output in_valid, mode, half, xin, yin, wr, out_ready,
        input  in_ready, out_valid, xout, yout, busy, err_range
    );

    // Butterfly side
    modport slave (
        input  in_valid, mode, half, xin, yin, wr, out_ready,
        output in_ready, out_valid, xout, yout, busy, err_range
    );
endinterface

// File: rtl/ntt_bfly_cfg_pipe.sv
// Fully pipelined radix-2 modular butterfly (CT forward / GS inverse with optional halving).
// Pipeline: S0 input register + range reduction, MUL_LAT multiply/fold stages, output stage.
// The whole pipeline advances together when the output register is free or being drained.
module ntt_bfly_cfg_pipe #(
    parameter int unsigned  W       = 33,
    parameter logic [W-1:0] P       = W'(64'd8588886017),
    parameter int unsigned  MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               reset,
    ntt_bfly_cfg_pipe_if.slave bus
);

    // 2^W mod P; small because P sits just below 2^W, so folding the product
    // high word by this constant shrinks it quickly.
    localparam logic [W-1:0] C  = ~P + W'(1);
    localparam int unsigned  CW = $clog2({1'b0, C} + {{W{1'b0}}, 1'b1});

    // Number of high-word folds needed until the residue is guaranteed < 2P
    // (assumes C <= 2^(W-2), which holds for the NTT-friendly moduli used here).
    function automatic int unsigned count_folds();
        int unsigned b;
        int unsigned hb;
        int unsigned nf;
        logic        done;
        b    = 2 * W;
        nf   = 0;
        done = 1'b0;
        for (int unsigned i = 0; i < 2 * W; i++) begin
            if (!done) begin
                nf = nf + 1;
                hb = b - W;
                if (hb + CW <= W - 1) begin
                    done = 1'b1;
                end else begin
                    b = ((hb + CW > W) ? hb + CW : W) + 1;
                end
            end
        end
        return nf;
    endfunction

    localparam int unsigned NFOLD = count_folds();

    // One conditional subtract of P
    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] a);
        return (a >= P) ? a - P : a;
    endfunction

    // (a + b) mod P for a, b in [0,P)
    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[W-1:0];
    endfunction

    // (a - b) mod P for a, b in [0,P); borrow out of bit W means negative
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) begin
            d = d + {1'b0, P};
        end
        return d[W-1:0];
    endfunction

    // a * 2^-1 mod P: odd values borrow P to become even first
    function automatic logic [W-1:0] halve(input logic [W-1:0] a);
        logic [W:0] t;
        t = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return t[W:1];
    endfunction

    // hi*2^W + lo  ->  hi*C + lo  (congruent mod P, strictly smaller for large inputs)
    function automatic logic [2*W-1:0] fold(input logic [2*W-1:0] v);
        logic [2*W-1:0] hi;
        logic [2*W-1:0] lo;
        hi = {{W{1'b0}}, v[2*W-1:W]};
        lo = {{W{1'b0}}, v[W-1:0]};
        return lo + hi * {{W{1'b0}}, C};
    endfunction

    // Pipeline state
    logic                 adv;
    logic                 accept;
    logic                 range_bad;
    logic                 v0;
    logic                 mode0;
    logic                 half0;
    logic [W-1:0]         x0;
    logic [W-1:0]         y0;
    logic [W-1:0]         w0;
    logic [MUL_LAT-1:0]   mv;
    logic [MUL_LAT-1:0]   mmode;
    logic [MUL_LAT-1:0]   mhalf;
    logic [W-1:0]         mcarry  [MUL_LAT];
    logic [2*W-1:0]       mprod   [MUL_LAT];
    logic [2*W-1:0]       prod_in [MUL_LAT];
    logic [W-1:0]         diff0;
    logic [W-1:0]         sum0;
    logic [W-1:0]         mop0;
    logic [W-1:0]         carry0;
    logic [2*W-1:0]       res_fold;
    logic [W-1:0]         tw;
    logic [W-1:0]         cx;
    logic [W-1:0]         xo;
    logic [W-1:0]         yo;
    logic                 out_valid_q;
    logic [W-1:0]         xout_q;
    logic [W-1:0]         yout_q;
    logic                 err_q;

    assign adv       = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && adv;
    assign range_bad = (bus.xin >= P) || (bus.yin >= P) || (bus.wr >= P);

    // Stage S0 -> M0 pre-add/sub and raw product; later multiply stages fold the product
    always_comb begin
        diff0      = sub_mod(x0, y0);
        sum0       = add_mod(x0, y0);
        mop0       = mode0 ? diff0 : y0;
        carry0     = mode0 ? sum0 : x0;
        prod_in[0] = {{W{1'b0}}, mop0} * {{W{1'b0}}, w0};
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            prod_in[i] = (i <= NFOLD) ? fold(mprod[i-1]) : mprod[i-1];
        end
    end

    // Output stage: leftover folds, final subtract, butterfly add/sub and optional halving
    always_comb begin
        res_fold = mprod[MUL_LAT-1];
        for (int unsigned k = 0; k < NFOLD; k++) begin
            if (k + 1 >= MUL_LAT) begin
                res_fold = fold(res_fold);
            end
        end
        tw = (res_fold >= {{W{1'b0}}, P}) ? W'(res_fold - {{W{1'b0}}, P}) : W'(res_fold);
        cx = mcarry[MUL_LAT-1];
        xo = add_mod(cx, tw);
        yo = sub_mod(cx, tw);
        if (mmode[MUL_LAT-1]) begin
            xo = mhalf[MUL_LAT-1] ? halve(cx) : cx;
            yo = mhalf[MUL_LAT-1] ? halve(tw) : tw;
        end
    end

    // Datapath registers: no reset needed, qualified by the valid chain
    always_ff @(posedge clk) begin
        if (adv) begin
            x0        <= reduce_once(bus.xin);
            y0        <= reduce_once(bus.yin);
            w0        <= reduce_once(bus.wr);
            mode0     <= bus.mode;
            half0     <= bus.half;
            mmode[0]  <= mode0;
            mhalf[0]  <= half0;
            mcarry[0] <= carry0;
            mprod[0]  <= prod_in[0];
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                mmode[i]  <= mmode[i-1];
                mhalf[i]  <= mhalf[i-1];
                mcarry[i] <= mcarry[i-1];
                mprod[i]  <= prod_in[i];
            end
        end
    end

    // Valid chain, output registers and sticky range error
    always_ff @(posedge clk) begin
        if (reset) begin
            v0          <= 1'b0;
            mv          <= '0;
            out_valid_q <= 1'b0;
            xout_q      <= '0;
            yout_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept && range_bad) begin
                err_q <= 1'b1;
            end
            if (adv) begin
                v0    <= bus.in_valid;
                mv[0] <= v0;
                for (int unsigned i = 1; i < MUL_LAT; i++) begin
                    mv[i] <= mv[i-1];
                end
                out_valid_q <= mv[MUL_LAT-1];
                if (mv[MUL_LAT-1]) begin
                    xout_q <= xo;
                    yout_q <= yo;
                end
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.xout      = xout_q;
    assign bus.yout      = yout_q;
    assign bus.busy      = v0 || (|mv) || out_valid_q;
    assign bus.err_range = err_q;

endmodule
